// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_arb_pkg
// Description : Shared types and constants for the register-file access
//               arbiter: FSM state encoding, requester-index width helper
//               and the default parked read address.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

   // Unmapped address the read port rests on when no read is in flight
   localparam logic [7:0] C_PARK_ADDR = 8'hFF;

   // Requester index width; never narrower than one bit
   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. The requester at rr_ptr has
//               highest priority, priority then falls with increasing index
//               and wraps around to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    winner,
   output logic               any_req
);

   logic [NUM_REQ-1:0] w_mask;
   logic [NUM_REQ-1:0] w_hi;
   logic [NUM_REQ-1:0] w_pick;

   // Lowest set request at or above the pointer wins; otherwise wrap to the
   // lowest set request overall
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_mask[i] = (i >= int'(rr_ptr));
      end
      w_hi   = req & w_mask;
      w_pick = (|w_hi) ? w_hi : req;
      grant  = '0;
      winner = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_pick[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            winner   = ID_W'(i);
         end
      end
   end

   assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/regfile_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_access_arbiter
// Description : Round-robin arbiter sharing one register-file write port and
//               one read port between NUM_REQ requesters, one access at a
//               time (IDLE -> ACCESS -> RESP). The read address rests on
//               PARK_ADDR except during the single read ACCESS cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_access_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int                NUM_REQ   = 4,
   parameter int                ADDR_W    = 8,
   parameter int                DATA_W    = 32,
   parameter int                BE_W      = DATA_W / 8,
   parameter int                ID_W      = id_width(NUM_REQ),
   parameter logic [ADDR_W-1:0] PARK_ADDR = ADDR_W'(C_PARK_ADDR)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ*BE_W-1:0]   req_be,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rf_wr_en,
   output logic [ADDR_W-1:0]         rf_wr_addr,
   output logic [DATA_W-1:0]         rf_wr_data,
   output logic [BE_W-1:0]           rf_wr_be,
   output logic [ADDR_W-1:0]         rf_rd_addr,
   input  logic [DATA_W-1:0]         rf_rd_data
);

   arb_state_e          r_state;
   arb_state_e          w_state_next;

   logic [ID_W-1:0]     r_rr_ptr;
   logic [ID_W-1:0]     w_winner;
   logic [ID_W-1:0]     w_ptr_next;
   logic [NUM_REQ-1:0]  w_grant;
   logic                w_any;

   logic                w_sel_write;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic [BE_W-1:0]     w_sel_be;

   logic                r_write;
   logic [ID_W-1:0]     r_id;
   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic [BE_W-1:0]     r_wr_be;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic [DATA_W-1:0]   r_rsp_rdata;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req     (req_valid),
      .rr_ptr  (r_rr_ptr),
      .grant   (w_grant),
      .winner  (w_winner),
      .any_req (w_any)
   );

   // Grant is only offered while idle and out of reset
   assign req_ready  = ((r_state == ST_IDLE) && rst_n) ? w_grant : '0;

   // Pointer moves to the requester just after the winner, wrapping at the top
   assign w_ptr_next = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);

   // Select the winning requester's command fields
   always_comb begin
      w_sel_write = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_be    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_write = req_write[i];
            w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            w_sel_be    = req_be[i*BE_W +: BE_W];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state: accept, one access cycle, then hold response until taken
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_any)     w_state_next = ST_ACCESS;
         ST_ACCESS:                w_state_next = ST_RESP;
         ST_RESP:   if (rsp_ready) w_state_next = ST_IDLE;
         default:                  w_state_next = ST_IDLE;
      endcase
   end

   // Latch the accepted request, drive the register-file port for the single
   // ACCESS cycle, then capture the response data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_ptr    <= '0;
         r_write     <= 1'b0;
         r_id        <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_wr_be     <= '0;
         r_rd_addr   <= PARK_ADDR;
         r_rsp_rdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_rr_ptr <= w_ptr_next;
                  r_write  <= w_sel_write;
                  r_id     <= w_winner;
                  if (w_sel_write) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= w_sel_addr;
                     r_wr_data <= w_sel_wdata;
                     r_wr_be   <= w_sel_be;
                     r_rd_addr <= PARK_ADDR;
                  end else begin
                     r_wr_en   <= 1'b0;
                     r_rd_addr <= w_sel_addr;
                  end
               end
            end
            ST_ACCESS: begin
               r_wr_en     <= 1'b0;
               r_rd_addr   <= PARK_ADDR;
               r_rsp_rdata <= r_write ? '0 : rf_rd_data;
            end
            default: begin
            end
         endcase
      end
   end

   assign rsp_valid  = (r_state == ST_RESP);
   assign rsp_id     = r_id;
   assign rsp_rdata  = r_rsp_rdata;
   assign rf_wr_en   = r_wr_en;
   assign rf_wr_addr = r_wr_addr;
   assign rf_wr_data = r_wr_data;
   assign rf_wr_be   = r_wr_be;
   assign rf_rd_addr = r_rd_addr;

endmodule
`default_nettype wire
